// File: rtl/fp_reduce_seq.sv
`default_nettype none
// ============================================================================
// Module   : fp_reduce_seq
// Purpose  : Sequential fp32 reduction sequencer. Accepts a stream of
//            single-precision elements over a valid/ready handshake and keeps
//            a running accumulator. Each accepted element is combined with the
//            accumulator by an external combinational fp_addsub instance,
//            whose result is registered. After the element flagged with
//            in_last, the reduced scalar, an element count and a NaN flag are
//            presented on an output valid/ready handshake.
// Ports    : clk, reset (sync, active-high), clear (sync abort)
//            in_valid/in_ready/in_data/in_sub/in_last  - element stream
//            add_a/add_b/add_sub -> fp_addsub inputs, add_y <- fp_addsub.y
//            out_valid/out_ready/out_data/out_count/out_nan - result
// Revision : 1.0 - initial release
// ============================================================================
module fp_reduce_seq #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_data,
  input  logic             in_sub,
  input  logic             in_last,
  output logic [31:0]      add_a,
  output logic [31:0]      add_b,
  output logic             add_sub,
  input  logic [31:0]      add_y,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_data,
  output logic [CNT_W-1:0] out_count,
  output logic             out_nan
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ACC  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] c_CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t           r_state;
  logic [31:0]      r_acc;
  logic [CNT_W-1:0] r_count;
  logic             r_nan;
  logic             r_out_valid;

  logic             w_accept;
  logic             w_in_nan;
  logic [CNT_W-1:0] w_count_inc;
  logic [31:0]      w_first_val;

  // Ready is gated by reset directly so nothing is accepted in a reset cycle.
  assign in_ready    = (r_state != ST_DONE) && !reset;
  assign w_accept    = in_valid && in_ready;
  assign w_in_nan    = (&in_data[30:23]) && (|in_data[22:0]);
  assign w_count_inc = (&r_count) ? r_count : (r_count + c_CNT_ONE);
  // The first element bypasses the adder; subtraction is a sign flip.
  assign w_first_val = in_sub ? {~in_data[31], in_data[30:0]} : in_data;

  assign add_a     = r_acc;
  assign add_b     = in_data;
  assign add_sub   = in_sub;

  assign out_valid = r_out_valid;
  assign out_data  = r_acc;
  assign out_count = r_count;
  assign out_nan   = r_nan;

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      // Any element offered in this cycle is dropped, not counted.
      r_state     <= ST_IDLE;
      r_acc       <= 32'h0;
      r_count     <= '0;
      r_nan       <= 1'b0;
      r_out_valid <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_acc       <= w_first_val;
            r_count     <= c_CNT_ONE;
            r_nan       <= w_in_nan;
            r_state     <= in_last ? ST_DONE : ST_ACC;
            r_out_valid <= in_last;
          end
        end
        ST_ACC: begin
          if (w_accept) begin
            r_acc       <= add_y;
            r_count     <= w_count_inc;
            r_nan       <= r_nan | w_in_nan;
            r_state     <= in_last ? ST_DONE : ST_ACC;
            r_out_valid <= in_last;
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            r_state     <= ST_IDLE;
            r_acc       <= 32'h0;
            r_count     <= '0;
            r_nan       <= 1'b0;
            r_out_valid <= 1'b0;
          end
        end
        default: begin
          r_state     <= ST_IDLE;
          r_acc       <= 32'h0;
          r_count     <= '0;
          r_nan       <= 1'b0;
          r_out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: doc/fp_reduce_seq.md
# fp_reduce_seq

Sequential floating-point reduction sequencer sitting directly upstream of the combinational `fp_addsub` datapath in the vector coprocessor. It accepts a stream of IEEE-754 single-precision elements over a valid/ready handshake and holds a running accumulator. Each cycle it drives that accumulator and the incoming element into an external `fp_addsub` instance, then registers the returned sum. When the last element is consumed it presents the reduced scalar, an element count and a NaN flag on an output handshake.

## Interface
- `CNT_W`, default 16: width of the element counter.
- `clk` input 1: clock. One clock domain.
- `reset` input 1: reset. Synchronous and active-high.
- `clear` input 1: synchronous abort. Returns the block to IDLE; lower priority than `reset`.
- `in_valid` input 1: element valid.
- `in_ready` output 1: element accepted on a cycle where `in_valid && in_ready`.
- `in_data` input 32: fp32 element.
- `in_sub` input 1: when 1, the element is subtracted instead of added.
- `in_last` input 1: marks the final element of the reduction.
- `add_a` output 32: drives `fp_addsub.a`.
- `add_b` output 32: drives `fp_addsub.b`.
- `add_sub` output 1: drives `fp_addsub.subtract`.
- `add_y` input 32: result from `fp_addsub.y`.
- `out_valid` output 1: result valid.
- `out_ready` input 1: result consumed on a cycle where `out_valid && out_ready`.
- `out_data` output 32: reduced value.
- `out_count` output CNT_W: number of elements accepted.
- `out_nan` output 1: at least one input was a NaN (exp == 8'hFF, frac != 0).

## Operation
- States:
  - IDLE: waiting for the first element.
  - ACC: accumulating.
  - DONE: result held on the output.
- `in_ready` = (state == IDLE || state == ACC) && !reset. `out_valid` = (state == DONE).
- `add_a` = acc, `add_b` = in_data, `add_sub` = in_sub. These are driven combinationally every cycle.
- IDLE, on accept:
  - acc <= in_sub ? {~in_data[31], in_data[30:0]} : in_data. The adder is bypassed.
  - count <= 1; nan <= isnan(in_data).
  - Next state is DONE if `in_last`, otherwise ACC.
- ACC, on accept:
  - acc <= add_y.
  - count <= count + 1, saturating at all-ones.
  - nan <= nan | isnan(in_data).
  - Next state is DONE if `in_last`, otherwise stays ACC.
- ACC with no accept: all registers hold.
- DONE:
  - `out_data` = acc, `out_count` = count, `out_nan` = nan. These stay stable while `out_valid && !out_ready`.
  - On handshake: go to IDLE; acc, count and nan are cleared to 0.
- `in_sub` on the first element negates it, so the result is the signed sum −x0 ± … .
- `clear`: next state IDLE; acc, count and nan are zeroed. Any in-flight element on that cycle is dropped; a handshake that coincides with `clear` is not counted.
- `reset`: same register effect as `clear`, and it also forces `in_ready` low during the reset cycle.
- `in_last` is ignored unless the element is accepted.

## Timing
- Reset values:
  - state IDLE; acc 0; count 0; nan 0.
  - `out_valid` 0; `out_data` 0; `out_count` 0; `out_nan` 0.
  - `in_ready` 0 while `reset` is high, 1 on the first cycle after deassertion.
- Throughput: one element per cycle, with no bubbles between elements.
- Latency: the accumulator updates on the edge ending the accept cycle. `out_valid` rises the cycle after the `in_last` accept.
- Occupancy: after the `out_ready` handshake the block is back in IDLE, and `in_ready` = 1 on the next cycle. Minimum gap between reductions is one DONE cycle.
- Input stability: `in_data` and `in_sub` must be stable during the accept cycle, because the combinational `add_y` is sampled at that edge.

## Test plan
- Sum stream:
  - Stimulus: 3F800000 (1.0), 40000000 (2.0), 40400000 (3.0, `in_last`), back-to-back, `out_ready` = 1.
  - Response: `out_valid` the cycle after the third accept; `out_data` 40C00000 (6.0); `out_count` 3; `out_nan` 0.
- Subtract on first element:
  - Stimulus: 40A00000 (5.0) with `in_sub` = 1, then 40000000 (2.0) with `in_last`.
  - Response: `out_data` C0400000 (−3.0); `out_count` 2.
- Single element with backpressure:
  - Stimulus: 3F800000 with `in_last`; `out_ready` held low for 5 cycles.
  - Response: `out_valid` and `out_data` 3F800000 held stable for all 5 cycles; `in_ready` = 0 throughout; IDLE the cycle after `out_ready` rises.
- NaN flag:
  - Stimulus: 3F800000, 7FC00001, 40000000 (`in_last`).
  - Response: `out_nan` = 1; `out_count` 3.
- Abort:
  - Stimulus: `clear` asserted after 2 of 4 elements; then a fresh 40000000 with `in_last`.
  - Response: `out_data` 40000000; `out_count` 1. Repeat with `reset` in place of `clear`: `in_ready` = 0 during reset, all outputs 0.
- Gaps:
  - Stimulus: `in_valid` toggled 1/0 across 4 elements of 3F800000.
  - Response: `out_data` 40800000 (4.0); `out_count` 4; acc unchanged on idle cycles.
